// File: rtl/vn_debias_packer.sv
// Von Neumann debiaser and word packer for the raw metastable bit stream,
// with a repetition-count health test that latches a sticky failure.
module vn_debias_packer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int REP_LIMIT   = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             raw_bit,
    input  logic             raw_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail,
    output logic [15:0]      drop_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [7:0] REP_LIMIT_W = 8'(REP_LIMIT);
    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {WAIT_FIRST, HAVE_FIRST} vn_state_t;

    logic [SYNC_STAGES-1:0] sync_bit_reg, sync_valid_reg;
    logic                   s_bit, s_valid;

    logic [7:0]  run_cnt_reg, run_cnt_next;
    logic        prev_bit_reg, have_prev_reg;
    logic        health_fail_reg, health_set;

    vn_state_t   vn_state_reg;
    logic        first_bit_reg;
    logic        emit, emit_bit;

    logic [WIDTH-1:0] word_reg, word_next, word_with_bit;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             data_valid_reg, data_valid_next;
    logic [15:0]      drop_reg, drop_next;
    logic             pack_en, blocked, out_free, held, load;

    // raw_valid travels with raw_bit so the aligned sample stays paired.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_bit_reg   <= '0;
            sync_valid_reg <= '0;
        end else begin
            sync_bit_reg   <= {sync_bit_reg[SYNC_STAGES-2:0], raw_bit};
            sync_valid_reg <= {sync_valid_reg[SYNC_STAGES-2:0], raw_valid};
        end
    end

    assign s_bit   = sync_bit_reg[SYNC_STAGES-1];
    assign s_valid = sync_valid_reg[SYNC_STAGES-1];

    always_comb begin
        run_cnt_next = run_cnt_reg;
        if (s_valid) begin
            if (have_prev_reg && (s_bit == prev_bit_reg))
                run_cnt_next = (run_cnt_reg == 8'hFF) ? run_cnt_reg : run_cnt_reg + 8'd1;
            else
                run_cnt_next = 8'd1;
        end
    end

    assign health_set = s_valid && (run_cnt_next >= REP_LIMIT_W);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            run_cnt_reg     <= '0;
            prev_bit_reg    <= 1'b0;
            have_prev_reg   <= 1'b0;
            health_fail_reg <= 1'b0;
        end else begin
            run_cnt_reg <= run_cnt_next;
            if (s_valid) begin
                prev_bit_reg  <= s_bit;
                have_prev_reg <= 1'b1;
            end
            if (health_set)
                health_fail_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vn_state_reg  <= WAIT_FIRST;
            first_bit_reg <= 1'b0;
        end else if (s_valid) begin
            case (vn_state_reg)
                WAIT_FIRST: begin
                    first_bit_reg <= s_bit;
                    vn_state_reg  <= HAVE_FIRST;
                end
                default: vn_state_reg <= WAIT_FIRST;
            endcase
        end
    end

    // Pair 10 emits 1, pair 01 emits 0: the emitted bit is the first of the pair.
    assign emit     = s_valid && (vn_state_reg == HAVE_FIRST) && (s_bit != first_bit_reg);
    assign emit_bit = first_bit_reg;

    assign pack_en  = emit && !health_fail_reg;
    assign blocked  = health_fail_reg || health_set;
    assign out_free = !data_valid_reg || data_ready;
    assign held     = (count_reg == COUNT_FULL);

    always_comb begin
        word_with_bit = word_reg;
        for (int i = 0; i < WIDTH; i++)
            if (count_reg == CW'(i))
                word_with_bit[i] = emit_bit;
    end

    always_comb begin
        count_next    = count_reg;
        word_next     = word_reg;
        drop_next     = drop_reg;
        load          = 1'b0;
        data_out_next = data_out_reg;
        if (held) begin
            if (out_free && !blocked) begin
                load          = 1'b1;
                data_out_next = word_reg;
                count_next    = '0;
                if (pack_en) begin
                    word_next  = {word_reg[WIDTH-1:1], emit_bit};
                    count_next = CW'(1);
                end
            end else if (pack_en && (drop_reg != 16'hFFFF)) begin
                drop_next = drop_reg + 16'd1;
            end
        end else if (pack_en) begin
            word_next = word_with_bit;
            if (count_reg == COUNT_LAST) begin
                if (out_free && !blocked) begin
                    load          = 1'b1;
                    data_out_next = word_with_bit;
                    count_next    = '0;
                end else begin
                    count_next = COUNT_FULL;
                end
            end else begin
                count_next = count_reg + CW'(1);
            end
        end
    end

    always_comb begin
        data_valid_next = data_valid_reg;
        if (load)
            data_valid_next = 1'b1;
        else if (data_valid_reg && data_ready)
            data_valid_next = 1'b0;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            word_reg       <= '0;
            count_reg      <= '0;
            drop_reg       <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            word_reg       <= word_next;
            count_reg      <= count_next;
            drop_reg       <= drop_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
        end
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign health_fail = health_fail_reg;
    assign drop_count  = drop_reg;

endmodule

// File: tb/tb_vn_debias_packer.sv
// Directed bench for vn_debias_packer: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_vn_debias_packer;

    localparam int W = 8;
    localparam int S = 2;
    localparam int R = 32;

    logic         clk_in = 1'b0;
    logic         rst, raw_bit, raw_valid, data_ready;
    logic [W-1:0] data_out;
    logic         data_valid, health_fail;
    logic [15:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    vn_debias_packer #(.WIDTH(W), .SYNC_STAGES(S), .REP_LIMIT(R)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .health_fail(health_fail),
        .drop_count (drop_count)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: delayed samples, pair extraction, bit queue, one output slot.
    bit           pb[S];
    bit           pv[S];
    int           m_run;
    bit           m_prev, m_have_prev, m_have_first, m_first;
    int           mq[$];
    logic [W-1:0] m_out;
    bit           m_valid, m_hf;
    int           m_drop;

    function automatic logic [W-1:0] queue_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) w[i] = mq[i][0];
        return w;
    endfunction

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < S; i++) begin pb[i] = 0; pv[i] = 0; end
            m_run = 0; m_prev = 0; m_have_prev = 0; m_have_first = 0; m_first = 0;
            mq.delete();
            m_out = '0; m_valid = 0; m_hf = 0; m_drop = 0;
        end else begin : step
            bit sb, sv, emit, ebit, set_now, free, blocked, loaded, acc;
            sb = pb[S-1]; sv = pv[S-1];
            for (int i = S - 1; i > 0; i--) begin pb[i] = pb[i-1]; pv[i] = pv[i-1]; end
            pb[0] = raw_bit; pv[0] = raw_valid;
            emit = 0; ebit = 0; set_now = 0; loaded = 0;
            acc  = m_valid && data_ready;
            free = !m_valid || data_ready;
            if (sv) begin
                m_run = (m_have_prev && sb == m_prev) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                m_prev = sb; m_have_prev = 1;
                set_now = (m_run >= R);
                if (!m_have_first) begin
                    m_first = sb; m_have_first = 1;
                end else begin
                    m_have_first = 0;
                    if (sb != m_first) begin emit = 1; ebit = m_first; end
                end
            end
            blocked = m_hf || set_now;
            if (mq.size() == W && free && !blocked) begin
                m_out = queue_word(); mq.delete(); loaded = 1;
            end
            if (emit && !m_hf) begin
                if (mq.size() == W) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back(int'(ebit));
                end
            end
            if (!loaded && mq.size() == W && free && !blocked) begin
                m_out = queue_word(); mq.delete(); loaded = 1;
            end
            if (loaded) m_valid = 1;
            else if (acc) m_valid = 0;
            if (set_now) m_hf = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (check_en && !rst) begin
            chk("model_data_valid", 32'(data_valid), 32'(m_valid));
            if (m_valid) chk("model_data_out", 32'(data_out), 32'(m_out));
            chk("model_health_fail", 32'(health_fail), 32'(m_hf));
            chk("model_drop_count", 32'(drop_count), 32'(m_drop));
        end
    end

    // One raw sample per call; returns just after the negedge following its capture edge.
    task automatic drv(input bit b, input bit v);
        raw_bit = b; raw_valid = v;
        @(negedge clk_in);
    endtask

    task automatic reset_dut();
        rst = 1'b1; raw_valid = 1'b0;
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    bit p2[24] = '{0,1, 1,0, 0,0, 1,1, 0,1, 1,0, 0,1, 1,0, 0,1, 1,0, 0,1, 1,0};
    bit w5[8]  = '{0,0,1,1,1,1,0,0};
    bit saw_valid;

    initial begin
        rst = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0; data_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_health_fail", 32'(health_fail), 32'h0);
        chk("reset_drop_count", 32'(drop_count), 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        check_en = 1'b1;

        // Alternating stream, consumer always ready
        data_ready = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            drv(bit'(i % 2), 1'b1);
            if (i == 17) chk("alt_valid_before_18", 32'(data_valid), 32'h0);
            if (i == 18) begin
                chk("alt_valid_at_18", 32'(data_valid), 32'h1);
                chk("alt_data_ff", 32'(data_out), 32'hFF);
            end
        end
        chk("alt_health_ok", 32'(health_fail), 32'h0);

        // Mixed pairs including 00 and 11
        reset_dut();
        data_ready = 1'b0;
        for (int i = 0; i < 24; i++) drv(p2[i], 1'b1);
        drv(1'b0, 1'b0);
        drv(1'b0, 1'b0);
        chk("pairs_valid", 32'(data_valid), 32'h1);
        chk("pairs_data_aa", 32'(data_out), 32'hAA);

        // Backpressure: one word out, one held, rest dropped
        reset_dut();
        data_ready = 1'b0;
        for (int i = 1; i <= 40; i++) drv(bit'(i % 2), 1'b1);
        drv(1'b0, 1'b0);
        drv(1'b0, 1'b0);
        chk("bp_valid_held", 32'(data_valid), 32'h1);
        chk("bp_data_ff", 32'(data_out), 32'hFF);
        chk("bp_drop_4", 32'(drop_count), 32'd4);
        data_ready = 1'b1;
        drv(1'b0, 1'b0);
        chk("bp_second_word_valid", 32'(data_valid), 32'h1);
        chk("bp_second_word_ff", 32'(data_out), 32'hFF);
        drv(1'b0, 1'b0);
        chk("bp_drained", 32'(data_valid), 32'h0);
        saw_valid = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            drv(bit'(i % 2), 1'b1);
            if (data_valid) saw_valid = 1'b1;
        end
        chk("bp_flow_resumes", 32'(saw_valid), 32'h1);
        chk("bp_drop_stays_4", 32'(drop_count), 32'd4);

        // Repetition-count failure
        reset_dut();
        data_ready = 1'b1;
        for (int i = 1; i <= 32; i++) drv(1'b1, 1'b1);
        drv(1'b1, 1'b0);
        chk("hf_low_before_32nd", 32'(health_fail), 32'h0);
        drv(1'b0, 1'b0);
        chk("hf_set_on_32nd", 32'(health_fail), 32'h1);
        saw_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            drv(bit'(i % 2), 1'b1);
            if (data_valid) saw_valid = 1'b1;
        end
        chk("hf_no_words", 32'(saw_valid), 32'h0);
        chk("hf_sticky", 32'(health_fail), 32'h1);
        chk("hf_no_drops", 32'(drop_count), 32'h0);

        // Reset with a partial word (5 bits) in the packer
        reset_dut();
        data_ready = 1'b0;
        for (int i = 1; i <= 12; i++) drv(bit'(i % 2), 1'b1);
        rst = 1'b1; raw_valid = 1'b0;
        #1;
        chk("midrst_data_out", 32'(data_out), 32'h0);
        chk("midrst_data_valid", 32'(data_valid), 32'h0);
        chk("midrst_drop", 32'(drop_count), 32'h0);
        @(negedge clk_in);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drv(w5[i], 1'b1);
            drv(!w5[i], 1'b1);
        end
        drv(1'b0, 1'b0);
        drv(1'b0, 1'b0);
        chk("midrst_fresh_valid", 32'(data_valid), 32'h1);
        chk("midrst_fresh_3c", 32'(data_out), 32'h3C);

        // raw_valid toggling: invalid cycles carry a repeat of the last bit
        reset_dut();
        data_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            drv(bit'(k % 2), 1'b1);
            drv(bit'(k % 2), 1'b0);
        end
        chk("tog_valid_before_33", 32'(data_valid), 32'h0);
        drv(1'b0, 1'b0);
        chk("tog_valid_at_33", 32'(data_valid), 32'h1);
        chk("tog_data_ff", 32'(data_out), 32'hFF);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vn_debias_packer.md
Name: vn_debias_packer

Overview:
- Post-processing stage directly downstream of metastable_core; consumes its raw metastable_bit stream.
- Synchronises the raw bit and removes bias with a von Neumann extractor.
- Packs the debiased bits into WIDTH-bit words behind a valid/ready output handshake.
- Runs a repetition-count health test that latches a sticky failure and stops output.

Parameters:
- WIDTH, 8, output word width in bits (2..32).
- SYNC_STAGES, 2, flops in raw_bit synchroniser (≥2).
- REP_LIMIT, 32, consecutive identical raw samples that trigger health failure (2..255).

Ports:
- clk_in  input  1  single clock for whole block.
- rst  input  1  asynchronous, active-high reset.
- raw_bit  input  1  metastable_bit from metastable_core, possibly asynchronous to clk_in.
- raw_valid  input  1  sample strobe, synchronous to clk_in; 1 = sample raw_bit this cycle.
- data_out  output  WIDTH  packed random word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts word when data_valid & data_ready.
- health_fail  output  1  sticky repetition-count failure.
- drop_count  output  16  debiased bits discarded due to backpressure; saturates at 0xFFFF.

Behaviour:
- Reset: async assert clears all state immediately. data_out=0, data_valid=0, health_fail=0, drop_count=0, packer count=0, FSM=WAIT_FIRST, run counter=0. Reset mid-word discards the partial word.
- Synchroniser: raw_bit passes through SYNC_STAGES flops. raw_valid is delayed by the same SYNC_STAGES flops, giving the aligned sample s_bit/s_valid.
- Health test:
  - On each s_valid: if s_bit equals the previous sample, run counter increments (saturating); otherwise it resets to 1. The first sample after reset sets it to 1.
  - When the counter reaches REP_LIMIT, health_fail sets on that edge and stays set until rst.
- Von Neumann FSM (advances only on s_valid):
  - WAIT_FIRST: store s_bit as first; go to HAVE_FIRST.
  - HAVE_FIRST: if s_bit != first, emit debiased bit = first (pair 10 → 1, 01 → 0). If equal, emit nothing. Return to WAIT_FIRST in both cases.
- Packer:
  - Each emitted bit is written at index count (LSB first, bit 0 = oldest); count increments.
  - On the edge the WIDTH-th bit is written, the completed word transfers to data_out and data_valid goes high on that same edge, provided the output register is free: data_valid=0, or data_valid & data_ready in that cycle. count then returns to 0.
  - If the output register is not free, the packer holds the full word (count=WIDTH). Every further emitted bit is discarded and drop_count increments (saturating). The held word moves out on the first edge the output register becomes free.
- Output handshake:
  - data_out is stable while data_valid & !data_ready.
  - An accept with no replacement word clears data_valid on the next edge.
  - Simultaneous accept and new word: data_out is replaced and data_valid stays 1.
- Health failure:
  - Once health_fail=1, no new word loads into data_out and the packer stops accepting bits; these bits are not counted as drops.
  - A word already in data_out may still be consumed.
- Latency: raw sample at cycle t → FSM/health update at edge t+SYNC_STAGES. Best-case word: data_valid rises on the edge that consumes the 2·WIDTH-th aligned sample.
- Simultaneous events: the health_fail set edge blocks a word that would complete on the same edge.

Test Plan:
- Alternating raw stream 1,0,1,0… with raw_valid=1 and data_ready=1 → every pair "10" emits 1. data_out=0xFF, first data_valid at cycle 2 + 16; health_fail stays 0.
- Pairs 01,10,00,11,01,10,01,10,01,10,01,10 → 8 bits 0,1,0,1,0,1,0,1 (the 00 and 11 pairs emit nothing) → data_out=0xAA.
- Alternating stream with data_ready=0 for 40 cycles → one word held in data_out, one word held in the packer, drop_count=4. Releasing data_ready → second word appears on the following edge, then normal flow resumes.
- 32 consecutive raw 1s → health_fail rises on the edge of the 32nd aligned sample. Afterwards data_valid never re-asserts despite alternating input, until rst.
- Assert rst for 1 cycle midway through a word (count=5) → outputs zero immediately. The next word is built from fresh bits only and matches the expected value.
- raw_valid toggling 1,0,1,0 → FSM/packer advance only on valid samples. Word value is identical to the continuous-valid case; latency is doubled.
